// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Cache request/refill and memory port bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int PADDR_W = 20,
    parameter int LINE_W  = 128
);
    logic               ic_req_ren;
    logic [PADDR_W-1:0] ic_req_raddr;
    logic               ic_rec_en;
    logic [PADDR_W-1:0] ic_rec_addr;
    logic [LINE_W-1:0]  ic_rec_cacheline;

    logic               dc_req_ren;
    logic [PADDR_W-1:0] dc_req_raddr;
    logic               dc_req_wen;
    logic [PADDR_W-1:0] dc_req_waddr;
    logic [LINE_W-1:0]  dc_req_wcacheline;
    logic               dc_rec_en;
    logic [PADDR_W-1:0] dc_rec_addr;
    logic [LINE_W-1:0]  dc_rec_cacheline;
    logic               dc_wbuf_full;

    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_we;
    logic [PADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0]  mem_req_wdata;
    logic               mem_rsp_valid;
    logic [LINE_W-1:0]  mem_rsp_data;

    logic               err;

    modport slave (
        input  ic_req_ren, ic_req_raddr,
        input  dc_req_ren, dc_req_raddr, dc_req_wen, dc_req_waddr, dc_req_wcacheline,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output ic_rec_en, ic_rec_addr, ic_rec_cacheline,
        output dc_rec_en, dc_rec_addr, dc_rec_cacheline, dc_wbuf_full,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output err
    );

    modport master (
        output ic_req_ren, ic_req_raddr,
        output dc_req_ren, dc_req_raddr, dc_req_wen, dc_req_waddr, dc_req_wcacheline,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  ic_rec_en, ic_rec_addr, ic_rec_cacheline,
        input  dc_rec_en, dc_rec_addr, dc_rec_cacheline, dc_wbuf_full,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one memory port between I-cache refills and D-cache
//               refills/write-backs; routes in-order read data back by tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int PADDR_W       = 20,
    parameter int LINE_W        = 128,
    parameter int N_OUTSTANDING = 4,
    parameter int WB_DEPTH      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int c_WB_PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int c_WB_CW = $clog2(WB_DEPTH + 1);
    localparam int c_TG_PW = (N_OUTSTANDING > 1) ? $clog2(N_OUTSTANDING) : 1;
    localparam int c_TG_CW = $clog2(N_OUTSTANDING + 1);
    localparam logic [c_WB_PW-1:0] c_WB_LAST = c_WB_PW'(WB_DEPTH - 1);
    localparam logic [c_TG_PW-1:0] c_TG_LAST = c_TG_PW'(N_OUTSTANDING - 1);

    logic               r_ic_pend, r_dc_pend;
    logic [PADDR_W-1:0] r_ic_addr, r_dc_addr;

    logic [PADDR_W-1:0] r_wb_addr [WB_DEPTH];
    logic [LINE_W-1:0]  r_wb_data [WB_DEPTH];
    logic [WB_DEPTH-1:0] r_wb_vld;
    logic [c_WB_PW-1:0] r_wb_rd, r_wb_wr;
    logic [c_WB_CW-1:0] r_wb_cnt;
    logic               r_wb_full;

    logic               r_req_valid, r_req_we, r_req_src;
    logic [PADDR_W-1:0] r_req_addr;
    logic [LINE_W-1:0]  r_req_wdata;
    logic               r_rr;

    logic               r_tag_src  [N_OUTSTANDING];
    logic [PADDR_W-1:0] r_tag_addr [N_OUTSTANDING];
    logic [c_TG_PW-1:0] r_tag_rd, r_tag_wr;
    logic [c_TG_CW-1:0] r_tag_cnt;

    logic               r_ic_rec_en, r_dc_rec_en, r_err;
    logic [PADDR_W-1:0] r_ic_rec_addr, r_dc_rec_addr;
    logic [LINE_W-1:0]  r_ic_rec_data, r_dc_rec_data;

    logic               w_free, w_accept, w_tag_push, w_tag_pop, w_tag_room;
    logic [c_TG_CW-1:0] w_tag_cnt_nxt;
    logic               w_wb_full, w_wb_any, w_wb_pop, w_wb_push, w_hazard;
    logic [c_WB_CW-1:0] w_wb_cnt_nxt;
    logic               w_ic_ok, w_dc_ok, w_sel_wb, w_sel_ic, w_sel_dc, w_err_set;

    function automatic logic [c_WB_PW-1:0] f_wb_inc(input logic [c_WB_PW-1:0] p);
        return (p == c_WB_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [c_TG_PW-1:0] f_tg_inc(input logic [c_TG_PW-1:0] p);
        return (p == c_TG_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_accept      = r_req_valid & bus.mem_req_ready;
    assign w_free        = ~r_req_valid | bus.mem_req_ready;
    assign w_tag_push    = w_accept & ~r_req_we;
    assign w_tag_pop     = bus.mem_rsp_valid & (r_tag_cnt != '0);
    assign w_tag_cnt_nxt = r_tag_cnt + c_TG_CW'(w_tag_push) - c_TG_CW'(w_tag_pop);
    // A newly loaded read will push on acceptance, so reserve its slot now.
    assign w_tag_room    = w_tag_cnt_nxt < c_TG_CW'(N_OUTSTANDING);

    assign w_wb_full     = r_wb_cnt == c_WB_CW'(WB_DEPTH);
    assign w_wb_any      = r_wb_cnt != '0;
    assign w_wb_pop      = w_sel_wb;
    assign w_wb_push     = bus.dc_req_wen & (~w_wb_full | w_wb_pop);
    assign w_wb_cnt_nxt  = r_wb_cnt + c_WB_CW'(w_wb_push) - c_WB_CW'(w_wb_pop);

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (r_wb_vld[i] && (r_wb_addr[i] == r_dc_addr)) w_hazard = 1'b1;
        end
    end

    assign w_ic_ok = r_ic_pend;
    assign w_dc_ok = r_dc_pend & ~w_hazard;

    always_comb begin
        w_sel_wb = 1'b0;
        w_sel_ic = 1'b0;
        w_sel_dc = 1'b0;
        if (w_free) begin
            if (w_wb_full) begin
                w_sel_wb = 1'b1;
            end else if (w_tag_room && (w_ic_ok || w_dc_ok)) begin
                if (w_ic_ok && (!w_dc_ok || !r_rr)) w_sel_ic = 1'b1;
                else                                w_sel_dc = 1'b1;
            end else if (w_wb_any) begin
                w_sel_wb = 1'b1;
            end
        end
    end

    assign w_err_set = (bus.ic_req_ren & r_ic_pend & ~w_sel_ic)
                     | (bus.dc_req_ren & r_dc_pend & ~w_sel_dc)
                     | (bus.dc_req_wen & w_wb_full & ~w_wb_pop)
                     | (bus.mem_rsp_valid & (r_tag_cnt == '0));

    always_ff @(posedge clk or negedge rst_n) begin : p_pending
        if (!rst_n) begin
            r_ic_pend <= 1'b0;
            r_ic_addr <= '0;
            r_dc_pend <= 1'b0;
            r_dc_addr <= '0;
        end else begin
            if (bus.ic_req_ren && (!r_ic_pend || w_sel_ic)) begin
                r_ic_pend <= 1'b1;
                r_ic_addr <= bus.ic_req_raddr;
            end else if (w_sel_ic) begin
                r_ic_pend <= 1'b0;
            end
            if (bus.dc_req_ren && (!r_dc_pend || w_sel_dc)) begin
                r_dc_pend <= 1'b1;
                r_dc_addr <= bus.dc_req_raddr;
            end else if (w_sel_dc) begin
                r_dc_pend <= 1'b0;
            end
        end
    end

    // When full, push and pop share one slot; the push must win its valid bit.
    always_ff @(posedge clk or negedge rst_n) begin : p_wb_ctrl
        if (!rst_n) begin
            r_wb_rd   <= '0;
            r_wb_wr   <= '0;
            r_wb_cnt  <= '0;
            r_wb_vld  <= '0;
            r_wb_full <= 1'b0;
        end else begin
            if (w_wb_pop) begin
                r_wb_vld[r_wb_rd] <= 1'b0;
                r_wb_rd           <= f_wb_inc(r_wb_rd);
            end
            if (w_wb_push) begin
                r_wb_vld[r_wb_wr] <= 1'b1;
                r_wb_wr           <= f_wb_inc(r_wb_wr);
            end
            r_wb_cnt  <= w_wb_cnt_nxt;
            r_wb_full <= w_wb_cnt_nxt == c_WB_CW'(WB_DEPTH);
        end
    end

    always_ff @(posedge clk) begin : p_fifo_data
        if (w_wb_push) begin
            r_wb_addr[r_wb_wr] <= bus.dc_req_waddr;
            r_wb_data[r_wb_wr] <= bus.dc_req_wcacheline;
        end
        if (w_tag_push) begin
            r_tag_src[r_tag_wr]  <= r_req_src;
            r_tag_addr[r_tag_wr] <= r_req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_issue
        if (!rst_n) begin
            r_req_valid <= 1'b0;
            r_req_we    <= 1'b0;
            r_req_src   <= 1'b0;
            r_req_addr  <= '0;
            r_req_wdata <= '0;
            r_rr        <= 1'b0;
        end else if (w_free) begin
            r_req_valid <= w_sel_wb | w_sel_ic | w_sel_dc;
            if (w_sel_wb) begin
                r_req_we    <= 1'b1;
                r_req_src   <= 1'b1;
                r_req_addr  <= r_wb_addr[r_wb_rd];
                r_req_wdata <= r_wb_data[r_wb_rd];
            end else if (w_sel_ic) begin
                r_req_we    <= 1'b0;
                r_req_src   <= 1'b0;
                r_req_addr  <= r_ic_addr;
                r_req_wdata <= '0;
                r_rr        <= 1'b1;
            end else if (w_sel_dc) begin
                r_req_we    <= 1'b0;
                r_req_src   <= 1'b1;
                r_req_addr  <= r_dc_addr;
                r_req_wdata <= '0;
                r_rr        <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_tag_rsp
        if (!rst_n) begin
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_tag_cnt     <= '0;
            r_ic_rec_en   <= 1'b0;
            r_ic_rec_addr <= '0;
            r_ic_rec_data <= '0;
            r_dc_rec_en   <= 1'b0;
            r_dc_rec_addr <= '0;
            r_dc_rec_data <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_tag_push) r_tag_wr <= f_tg_inc(r_tag_wr);
            if (w_tag_pop)  r_tag_rd <= f_tg_inc(r_tag_rd);
            r_tag_cnt   <= w_tag_cnt_nxt;
            r_ic_rec_en <= w_tag_pop & ~r_tag_src[r_tag_rd];
            r_dc_rec_en <= w_tag_pop &  r_tag_src[r_tag_rd];
            if (w_tag_pop && !r_tag_src[r_tag_rd]) begin
                r_ic_rec_addr <= r_tag_addr[r_tag_rd];
                r_ic_rec_data <= bus.mem_rsp_data;
            end
            if (w_tag_pop && r_tag_src[r_tag_rd]) begin
                r_dc_rec_addr <= r_tag_addr[r_tag_rd];
                r_dc_rec_data <= bus.mem_rsp_data;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    assign bus.ic_rec_en        = r_ic_rec_en;
    assign bus.ic_rec_addr      = r_ic_rec_addr;
    assign bus.ic_rec_cacheline = r_ic_rec_data;
    assign bus.dc_rec_en        = r_dc_rec_en;
    assign bus.dc_rec_addr      = r_dc_rec_addr;
    assign bus.dc_rec_cacheline = r_dc_rec_data;
    assign bus.dc_wbuf_full     = r_wb_full;
    assign bus.mem_req_valid    = r_req_valid;
    assign bus.mem_req_we       = r_req_we;
    assign bus.mem_req_addr     = r_req_addr;
    assign bus.mem_req_wdata    = r_req_wdata;
    assign bus.err              = r_err;
endmodule
`default_nettype wire
